pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It detects load-use hazards and inserts one bubble into the ID/EX register. It squashes wrong-path instructions after a taken branch. It freezes the whole front end while the data memory reports busy. It drives the PC, IF/ID and ID/EX write/flush controls and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2, number of cycles IF/ID and ID/EX are flushed per taken branch (legal 1..7)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rd  in  5  destination register of instruction in EX
- if_id_rs1, if_id_rs2  in  5 each  source registers of instruction in ID
- if_id_uses_rs1, if_id_uses_rs2  in  1 each  ID instruction actually reads that source
- branch_taken  in  1  branch resolved taken this cycle (single-cycle pulse)
- mem_busy  in  1  data memory cannot complete this cycle
- perf_clear  in  1  synchronous clear of both counters
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may capture
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_hold  out  1  ID/EX keeps its contents
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits 0)
- ctrl_state  out  2  FSM state: RUN=0, FLUSH=1, PEND=2
- stall_count  out  CNT_W  cycles with pc_write=0
- flush_count  out  CNT_W  accepted branch flush events

## Operation
- load_use = id_ex_mem_read && id_ex_rd!=0 && ((if_id_uses_rs1 && id_ex_rd==if_id_rs1) || (if_id_uses_rs2 && id_ex_rd==if_id_rs2)).
- Output priority per cycle: reset > mem_busy > flush > load_use > normal.
- mem_busy=1, any state: pc_write=0, if_id_write=0, id_ex_hold=1, both flushes 0, FSM and flush counter frozen.
- RUN, not busy, branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1. flush_count++. Remaining counter r loads FLUSH_CYCLES-1. Next state is FLUSH if r>0, else RUN.
- RUN, not busy, load_use, no branch: pc_write=0, if_id_write=0, id_ex_flush=1. Stays RUN.
- RUN, none of the above: pc_write=1, if_id_write=1, all others 0.
- FLUSH, not busy: both flushes 1, pc_write=1, if_id_write=1. Decrement r; return to RUN when r reaches 0. branch_taken and load_use are ignored and not counted (they come from squashed instructions).
- RUN, mem_busy and branch_taken together: go to PEND, no flush yet. branch_taken during busy in FLUSH or PEND is ignored.
- PEND: held exactly as the busy case while mem_busy=1. On the first non-busy cycle, behaves as RUN+branch_taken: flush asserted, flush_count++, r loaded, next state FLUSH or RUN.
- Counters: stall_count increments every cycle pc_write=0 after reset release. Both counters saturate at all-ones. perf_clear wins over a same-cycle increment.
- Reset (rst_n low, immediate): state RUN, r=0, counters 0, pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, id_ex_hold=0.

## Timing
- Control outputs are combinational from state plus inputs, with zero latency. A hazard seen in cycle t is acted on at the edge ending cycle t.
- A taken branch in cycle t produces flushes in cycles t..t+FLUSH_CYCLES-1, excluding busy cycles, which stretch the window.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has left EX, so load_use drops naturally.
- State, r and counters update on the rising clk edge. Counter outputs reflect the event one cycle later.
- Reset deassertion is synchronised by the integrating level; the block itself assumes a clean edge.

## Structure
- Shared header pipe_ctrl_defs.vh holds the state encodings (RUN/FLUSH/PEND), the flush-counter width (3) and NOP/bubble constants used by the ID/EX and IF/ID registers.
- One combinational sub-module, load_use_detect, computes load_use. The FSM, flush counter and perf counters stay in the top.

## Test plan
- Load x5 in EX (mem_read=1, rd=5), ID reads rs1=5 -> one cycle pc_write=0, id_ex_flush=1; next cycle normal; stall_count=1.
- rd=0 load with rs1=0 -> no stall; pc_write stays 1.
- branch_taken at t with FLUSH_CYCLES=2 -> flushes at t and t+1, RUN at t+2; flush_count=1; a branch_taken at t+1 is ignored.
- mem_busy high 3 cycles with branch_taken in its first cycle -> PEND; 3 hold cycles (stall_count=3); flush on cycle 4 and 5, then RUN.
- Load-use and branch_taken in the same cycle -> flush only, pc_write=1, stall_count unchanged.
- Preload stall_count near all-ones, then hold a stall -> saturates. perf_clear with a simultaneous stall -> 0. rst_n low mid-FLUSH -> RUN and 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// the flush down-counter width and the NOP/bubble values the stage registers load.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_PEND  = 2'd2
   } ctrl_state_e;

   localparam int FLUSH_CNT_W = 3;

   // addi x0,x0,0 goes into IF/ID on a flush; ID/EX bubbles clear every control bit
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
   localparam logic [15:0] BUBBLE_CTRL = 16'h0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: the load in EX writes a register that the
// instruction in ID actually reads. A load to x0 never creates a hazard.
module load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       mem_read,
   input  logic [4:0] rd,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       uses_rs1,
   input  logic       uses_rs2,
   output logic       load_use
);

   assign load_use = mem_read && (rd != 5'd0) &&
                     ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use bubbles,
// branch squash window, memory-busy freeze and saturating stall/flush counters.
//
//   state | meaning
//   RUN   | normal issue; branches and load-use hazards are acted on here
//   FLUSH | squash window after a taken branch, r counts remaining cycles
//   PEND  | branch seen while memory busy, flush starts on first free cycle
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       id_ex_rd,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_uses_rs1,
   input  logic             if_id_uses_rs2,
   input  logic             branch_taken,
   input  logic             mem_busy,
   input  logic             perf_clear,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_hold,
   output logic             id_ex_flush,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [FLUSH_CNT_W-1:0] R_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [FLUSH_CNT_W-1:0] R_ONE  = FLUSH_CNT_W'(1);

   ctrl_state_e            state, state_nxt;
   logic [FLUSH_CNT_W-1:0] r, r_nxt;
   logic                   load_use;
   logic                   flush_evt;

   load_use_detect u_load_use_detect (
      .mem_read (id_ex_mem_read),
      .rd       (id_ex_rd),
      .rs1      (if_id_rs1),
      .rs2      (if_id_rs2),
      .uses_rs1 (if_id_uses_rs1),
      .uses_rs2 (if_id_uses_rs2),
      .load_use (load_use)
   );

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_hold  = 1'b0;
      id_ex_flush = 1'b0;
      state_nxt   = state;
      r_nxt       = r;
      flush_evt   = 1'b0;

      if (!rst_n) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_hold  = 1'b1;
         if (state == ST_RUN && branch_taken)
            state_nxt = ST_PEND;
      end else begin
         unique case (state)
            ST_RUN, ST_PEND: begin
               if (state == ST_PEND || branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  flush_evt   = 1'b1;
                  r_nxt       = R_LOAD;
                  state_nxt   = (R_LOAD != '0) ? ST_FLUSH : ST_RUN;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            ST_FLUSH: begin
               // branch_taken/load_use here belong to squashed instructions
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               r_nxt       = r - R_ONE;
               if (r == R_ONE)
                  state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         r           <= '0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state <= state_nxt;
         r     <= r_nxt;
         if (perf_clear) begin
            stall_count <= '0;
            flush_count <= '0;
         end else begin
            if (!pc_write && stall_count != '1)
               stall_count <= stall_count + CNT_W'(1);
            if (flush_evt && flush_count != '1)
               flush_count <= flush_count + CNT_W'(1);
         end
      end
   end

   assign ctrl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: the driver pushes hand-computed expected
// outputs into a queue, a monitor pops and compares once per cycle.
module tb_pipeline_hazard_ctrl;

   localparam int FC = 2;
   localparam int CW = 4;

   // control bundle {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush}
   localparam logic [4:0] NRM = 5'b11000;
   localparam logic [4:0] STL = 5'b00001;
   localparam logic [4:0] FLS = 5'b11101;
   localparam logic [4:0] HLD = 5'b00010;
   localparam logic [4:0] RST = 5'b00101;

   typedef struct packed {
      logic [4:0]    ctl;
      logic [1:0]    st;
      logic [CW-1:0] sc;
      logic [CW-1:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic id_ex_mem_read = 1'b0;
   logic [4:0] id_ex_rd = '0, if_id_rs1 = '0, if_id_rs2 = '0;
   logic if_id_uses_rs1 = 1'b0, if_id_uses_rs2 = 1'b0;
   logic branch_taken = 1'b0, mem_busy = 1'b0, perf_clear = 1'b0;
   logic pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush;
   logic [1:0] ctrl_state;
   logic [CW-1:0] stall_count, flush_count;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   vec   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_ex_mem_read (id_ex_mem_read),
      .id_ex_rd       (id_ex_rd),
      .if_id_rs1      (if_id_rs1),
      .if_id_rs2      (if_id_rs2),
      .if_id_uses_rs1 (if_id_uses_rs1),
      .if_id_uses_rs2 (if_id_uses_rs2),
      .branch_taken   (branch_taken),
      .mem_busy       (mem_busy),
      .perf_clear     (perf_clear),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .if_id_flush    (if_id_flush),
      .id_ex_hold     (id_ex_hold),
      .id_ex_flush    (id_ex_flush),
      .ctrl_state     (ctrl_state),
      .stall_count    (stall_count),
      .flush_count    (flush_count)
   );

   task automatic step(input logic rstn, busy, br, clr, mr,
                       input logic [4:0] rd, rs1, rs2,
                       input logic u1, u2,
                       input logic [4:0] ctl, input int st, sc, fc);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n          = rstn;
      mem_busy       = busy;
      branch_taken   = br;
      perf_clear     = clr;
      id_ex_mem_read = mr;
      id_ex_rd       = rd;
      if_id_rs1      = rs1;
      if_id_rs2      = rs2;
      if_id_uses_rs1 = u1;
      if_id_uses_rs2 = u2;
      e.ctl = ctl;
      e.st  = 2'(st);
      e.sc  = CW'(sc);
      e.fc  = CW'(fc);
      exp_q.push_back(e);
   endtask

   // monitor
   initial begin
      exp_t e;
      logic [4:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_flush};
            tests++;
            if (act !== e.ctl) begin
               fails++;
               $display("FAIL v%0d ctl: got %b want %b", vec, act, e.ctl);
            end
            tests++;
            if (ctrl_state !== e.st) begin
               fails++;
               $display("FAIL v%0d state: got %0d want %0d", vec, ctrl_state, e.st);
            end
            tests++;
            if (stall_count !== e.sc) begin
               fails++;
               $display("FAIL v%0d stall_count: got %0d want %0d", vec, stall_count, e.sc);
            end
            tests++;
            if (flush_count !== e.fc) begin
               fails++;
               $display("FAIL v%0d flush_count: got %0d want %0d", vec, flush_count, e.fc);
            end
            vec++;
         end
      end
   end

   // driver: rstn busy br clr mr rd rs1 rs2 u1 u2 | ctl st sc fc
   initial begin
      int waited;
      step(0,0,0,0, 0,0,0,0,0,0, RST,0,0,0);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,0,0);
      // load x5, ID reads rs1=x5: one bubble
      step(1,0,0,0, 1,5,5,0,1,0, STL,0,0,0);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,1,0);
      // load to x0 and an unused matching source never stall
      step(1,0,0,0, 1,0,0,0,1,0, NRM,0,1,0);
      step(1,0,0,0, 1,7,7,3,0,1, NRM,0,1,0);
      step(1,0,0,0, 1,9,1,9,0,1, STL,0,1,0);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,2,0);
      // taken branch: two flush cycles, second branch and load-use ignored
      step(1,0,1,0, 0,0,0,0,0,0, FLS,0,2,0);
      step(1,0,1,0, 1,5,5,0,1,0, FLS,1,2,1);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,2,1);
      // busy with branch in first cycle -> PEND, 3 holds, then flush window
      step(1,1,1,0, 0,0,0,0,0,0, HLD,0,2,1);
      step(1,1,0,0, 0,0,0,0,0,0, HLD,2,3,1);
      step(1,1,1,0, 0,0,0,0,0,0, HLD,2,4,1);
      step(1,0,0,0, 0,0,0,0,0,0, FLS,2,5,1);
      step(1,0,0,0, 0,0,0,0,0,0, FLS,1,5,2);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,5,2);
      // load-use together with branch: flush wins, no stall
      step(1,0,1,0, 1,5,5,0,1,0, FLS,0,5,2);
      step(1,0,0,0, 0,0,0,0,0,0, FLS,1,5,3);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,5,3);
      // busy inside FLUSH stretches the window
      step(1,0,1,0, 0,0,0,0,0,0, FLS,0,5,3);
      step(1,1,0,0, 0,0,0,0,0,0, HLD,1,5,4);
      step(1,0,0,0, 0,0,0,0,0,0, FLS,1,6,4);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,6,4);
      // long busy saturates stall_count at 15
      for (int k = 0; k < 12; k++)
         step(1,1,0,0, 0,0,0,0,0,0, HLD,0,((6+k) > 15) ? 15 : (6+k),4);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,15,4);
      // clear beats a same-cycle stall increment
      step(1,1,0,1, 0,0,0,0,0,0, HLD,0,15,4);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,0,0);
      // reset in the middle of a flush window
      step(1,0,1,0, 0,0,0,0,0,0, FLS,0,0,0);
      step(0,0,0,0, 0,0,0,0,0,0, RST,0,0,0);
      step(1,0,0,0, 0,0,0,0,0,0, NRM,0,0,0);

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (exp_q.size() > 0) begin
         fails++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
